// File: rtl/harmonic_pkg.sv
// Shared types and width derivations for the harmonic phase engine and its phase RAM.
package harmonic_pkg;

    localparam int PHASE_W_DEFAULT   = 16;
    localparam int FREQ_W_DEFAULT    = 16;
    localparam int HARMONICS_DEFAULT = 256;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        CALC,
        OUT
    } state_t;

    // Room for (HARMONICS) x (max frequency) so the running increment never wraps.
    function automatic int acc_width(input int freq_w, input int harm_w);
        return freq_w + harm_w + 1;
    endfunction

    function automatic longint nyquist_default(input int phase_w);
        return longint'(1) << (phase_w - 1);
    endfunction

endpackage

// File: rtl/phase_ram.sv
// Single-port phase store with a one-cycle registered read; contents survive reset.
module phase_ram
    import harmonic_pkg::*;
#(
    parameter int  DEPTH  = HARMONICS_DEFAULT,
    parameter int  WIDTH  = PHASE_W_DEFAULT,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] address,
    input  logic [WIDTH-1:0]  write_data,
    output logic [WIDTH-1:0]  read_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (write_enable) begin
            mem[address] <= write_data;
        end
        read_data <= mem[address];
    end

endmodule

// File: rtl/harmonic_phase_engine.sv
// Per-harmonic phase accumulator: each sample tick sweeps harmonics 0..count-1,
// advancing every stored phase by (n+1)*frequency and handing it to the sine-LUT stage.
module harmonic_phase_engine
    import harmonic_pkg::*;
#(
    parameter int     PHASE_W   = PHASE_W_DEFAULT,
    parameter int     FREQ_W    = FREQ_W_DEFAULT,
    parameter int     HARMONICS = HARMONICS_DEFAULT,
    parameter longint NYQUIST   = nyquist_default(PHASE_W),
    localparam int    HARM_W    = $clog2(HARMONICS)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [FREQ_W-1:0]  frequency,
    input  logic [HARM_W:0]    harmonic_count,
    input  logic               sample_tick,
    input  logic               sync,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [HARM_W-1:0]  out_harmonic,
    output logic [PHASE_W-1:0] out_phase,
    output logic               out_mute,
    output logic               out_last,
    output logic               busy,
    output logic               overrun
);

    localparam int               ACC_W   = acc_width(FREQ_W, HARM_W);
    localparam logic [ACC_W-1:0] NYQ_ACC = ACC_W'(NYQUIST);

    state_t             state_reg;
    logic [FREQ_W-1:0]  freq_reg;
    logic [HARM_W:0]    count_reg;
    logic [ACC_W-1:0]   inc_reg;
    logic [HARM_W-1:0]  idx_reg;
    logic               zero_reg;
    logic               sync_pending_reg;
    logic [PHASE_W-1:0] rd_data;
    logic [PHASE_W-1:0] phase_next;
    logic               last_next;
    logic               start;

    assign start      = sample_tick && (state_reg == IDLE) && (harmonic_count != '0);
    assign phase_next = zero_reg ? '0 : rd_data + PHASE_W'(inc_reg);
    assign last_next  = ({1'b0, idx_reg} == count_reg - (HARM_W + 1)'(1));
    assign busy       = (state_reg != IDLE);

    phase_ram #(
        .DEPTH (HARMONICS),
        .WIDTH (PHASE_W)
    ) u_phase_ram (
        .clock        (clock),
        .write_enable (state_reg == CALC),
        .address      (idx_reg),
        .write_data   (phase_next),
        .read_data    (rd_data)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg        <= IDLE;
            freq_reg         <= '0;
            count_reg        <= '0;
            inc_reg          <= '0;
            idx_reg          <= '0;
            zero_reg         <= 1'b0;
            sync_pending_reg <= 1'b1;  // RAM is not cleared, so the first sweep zeros it
            out_valid        <= 1'b0;
            out_harmonic     <= '0;
            out_phase        <= '0;
            out_mute         <= 1'b0;
            out_last         <= 1'b0;
            overrun          <= 1'b0;
        end else begin
            if (sample_tick && state_reg != IDLE) begin
                overrun <= 1'b1;
            end

            // A sync coinciding with the starting tick belongs to that sweep.
            if (start) begin
                zero_reg         <= sync_pending_reg | sync;
                sync_pending_reg <= 1'b0;
            end else if (sync) begin
                sync_pending_reg <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        freq_reg  <= frequency;
                        count_reg <= harmonic_count;
                        inc_reg   <= ACC_W'(frequency);
                        idx_reg   <= '0;
                        state_reg <= READ;
                    end
                end
                READ: state_reg <= CALC;
                CALC: begin
                    out_phase    <= phase_next;
                    out_harmonic <= idx_reg;
                    out_mute     <= (inc_reg >= NYQ_ACC);
                    out_last     <= last_next;
                    out_valid    <= 1'b1;
                    state_reg    <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            state_reg <= IDLE;
                        end else begin
                            idx_reg   <= idx_reg + HARM_W'(1);
                            inc_reg   <= inc_reg + ACC_W'(freq_reg);
                            state_reg <= READ;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_harmonic_phase_engine.sv
// Scoreboard bench: stimulus queues hand-computed outputs, a negedge monitor pops and compares.
module tb_harmonic_phase_engine;

    localparam int HARM_W = 8;

    logic               clock = 1'b0;
    logic               reset;
    logic [15:0]        frequency;
    logic [HARM_W:0]    harmonic_count;
    logic               sample_tick;
    logic               sync;
    logic               out_valid;
    logic               out_ready;
    logic [HARM_W-1:0]  out_harmonic;
    logic [15:0]        out_phase;
    logic               out_mute;
    logic               out_last;
    logic               busy;
    logic               overrun;

    harmonic_phase_engine dut (
        .clock          (clock),
        .reset          (reset),
        .frequency      (frequency),
        .harmonic_count (harmonic_count),
        .sample_tick    (sample_tick),
        .sync           (sync),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_harmonic   (out_harmonic),
        .out_phase      (out_phase),
        .out_mute       (out_mute),
        .out_last       (out_last),
        .busy           (busy),
        .overrun        (overrun)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          h;
        logic [15:0] ph;
        bit          mute;
        bit          last;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks   = 0;
    int   failures = 0;

    logic [15:0] nyq_ph2 [3] = '{16'h6000, 16'hC000, 16'h2000};
    logic [15:0] nyq_ph3 [3] = '{16'hC000, 16'h8000, 16'h4000};
    bit          nyq_mute [3] = '{1'b0, 1'b1, 1'b1};
    logic [15:0] rst_ph [5] = '{16'h0020, 16'h0040, 16'h0060, 16'h0080, 16'h00A0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic push(input int h, input logic [15:0] ph, input bit mute, input bit last);
        exp_t x;
        x.h = h; x.ph = ph; x.mute = mute; x.last = last;
        exp_q.push_back(x);
    endtask

    task automatic do_tick(input logic [15:0] f, input logic [HARM_W:0] n, input logic s);
        @(posedge clock); #1;
        frequency = f; harmonic_count = n; sample_tick = 1'b1; sync = s;
        @(posedge clock); #1;
        sample_tick = 1'b0; sync = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        check({name, "_finished"}, 32'(done), 32'd1);
        check({name, "_all_outputs_seen"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_harm(input int h);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (out_valid && out_harmonic == HARM_W'(h)) begin
                found = 1'b1;
                break;
            end
        end
        check($sformatf("reach_harmonic_%0d", h), 32'(found), 32'd1);
    endtask

    // Monitor: compares accepted outputs and checks fields hold while stalled.
    bit                prev_stall = 1'b0;
    logic [HARM_W-1:0] held_h;
    logic [15:0]       held_ph;
    logic              held_m;
    logic              held_l;

    always @(negedge clock) begin
        if (!reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid_held", 32'(out_valid), 32'd1);
                check("stall_harmonic_held", 32'(out_harmonic), 32'(held_h));
                check("stall_phase_held", 32'(out_phase), 32'(held_ph));
                check("stall_mute_held", 32'(out_mute), 32'(held_m));
                check("stall_last_held", 32'(out_last), 32'(held_l));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: got harmonic %0d phase 0x%04h required none",
                             out_harmonic, out_phase);
                end else begin
                    e = exp_q.pop_front();
                    $display("txn harmonic=%0d phase=0x%04h mute=%0d last=%0d",
                             out_harmonic, out_phase, out_mute, out_last);
                    check("harmonic", 32'(out_harmonic), 32'(e.h));
                    check("phase", 32'(out_phase), 32'(e.ph));
                    check("mute", 32'(out_mute), 32'(e.mute));
                    check("last", 32'(out_last), 32'(e.last));
                end
            end
            prev_stall = out_valid && !out_ready;
            held_h  = out_harmonic;
            held_ph = out_phase;
            held_m  = out_mute;
            held_l  = out_last;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; out_ready = 1'b1; frequency = '0; harmonic_count = '0;
        sample_tick = 1'b0; sync = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);
        check("reset_phase", 32'(out_phase), 32'd0);
        check("reset_harmonic", 32'(out_harmonic), 32'd0);
        check("reset_mute_last", 32'({out_mute, out_last}), 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;

        // Post-reset sweep zeros phases; check the tick-to-valid latency.
        for (int h = 0; h < 4; h++) push(h, 16'h0000, 1'b0, h == 3);
        do_tick(16'h0100, 9'd4, 1'b0);
        @(negedge clock);
        check("busy_at_T1", 32'(busy), 32'd1);
        check("valid_at_T1", 32'(out_valid), 32'd0);
        @(negedge clock);
        check("valid_at_T2", 32'(out_valid), 32'd0);
        @(negedge clock);
        check("valid_at_T3", 32'(out_valid), 32'd1);
        wait_idle("sweep_post_reset");

        for (int h = 0; h < 4; h++) push(h, 16'((h + 1) * 16'h0100), 1'b0, h == 3);
        do_tick(16'h0100, 9'd4, 1'b0);
        wait_idle("sweep_second");
        for (int h = 0; h < 4; h++) push(h, 16'((h + 1) * 16'h0200), 1'b0, h == 3);
        do_tick(16'h0100, 9'd4, 1'b0);
        wait_idle("sweep_third");

        // Zero-count tick with sync: ignored, but the sync stays pending.
        do_tick(16'h6000, 9'd0, 1'b1);
        @(negedge clock);
        check("zero_count_no_sweep", 32'(busy), 32'd0);
        check("zero_count_no_overrun", 32'(overrun), 32'd0);

        for (int h = 0; h < 3; h++) push(h, 16'h0000, nyq_mute[h], h == 2);
        do_tick(16'h6000, 9'd3, 1'b0);
        wait_idle("nyq_zeroing");
        for (int h = 0; h < 3; h++) push(h, nyq_ph2[h], nyq_mute[h], h == 2);
        do_tick(16'h6000, 9'd3, 1'b0);
        wait_idle("nyq_sweep2");
        for (int h = 0; h < 3; h++) push(h, nyq_ph3[h], nyq_mute[h], h == 2);
        do_tick(16'h6000, 9'd3, 1'b0);
        wait_idle("nyq_sweep3");

        // Backpressure on harmonic 1.
        for (int h = 0; h < 4; h++) push(h, 16'h0000, 1'b0, h == 3);
        do_tick(16'h0100, 9'd4, 1'b1);
        wait_harm(0);
        @(posedge clock); #1;
        out_ready = 1'b0;
        repeat (12) @(posedge clock);
        #1 out_ready = 1'b1;
        wait_idle("backpressure");

        // Overrun tick at idx 2, sync at idx 4 of an 8-harmonic sweep.
        for (int h = 0; h < 8; h++) push(h, 16'h0000, 1'b0, h == 7);
        do_tick(16'h0010, 9'd8, 1'b1);
        wait_harm(2);
        @(posedge clock); #1 sample_tick = 1'b1;
        @(posedge clock); #1 sample_tick = 1'b0;
        @(negedge clock);
        check("overrun_set", 32'(overrun), 32'd1);
        wait_harm(4);
        @(posedge clock); #1 sync = 1'b1;
        @(posedge clock); #1 sync = 1'b0;
        wait_idle("overrun_sweep");
        for (int h = 0; h < 8; h++) push(h, 16'h0000, 1'b0, h == 7);
        do_tick(16'h0010, 9'd8, 1'b0);
        wait_idle("sync_zero_sweep");
        for (int h = 0; h < 8; h++) push(h, 16'((h + 1) * 16'h0010), 1'b0, h == 7);
        do_tick(16'h0010, 9'd8, 1'b0);
        wait_idle("after_sync_sweep");
        check("overrun_sticky", 32'(overrun), 32'd1);

        // Reset while harmonic 5 is being presented.
        for (int h = 0; h < 5; h++) push(h, rst_ph[h], 1'b0, 1'b0);
        do_tick(16'h0010, 9'd8, 1'b0);
        wait_harm(4);
        @(posedge clock); #1 out_ready = 1'b0;
        wait_harm(5);
        @(posedge clock); #1 reset = 1'b0;
        @(posedge clock); #1 reset = 1'b1; out_ready = 1'b1;
        @(negedge clock);
        check("midreset_valid", 32'(out_valid), 32'd0);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_overrun", 32'(overrun), 32'd0);
        check("midreset_phase", 32'(out_phase), 32'd0);
        check("midreset_harmonic", 32'(out_harmonic), 32'd0);
        check("midreset_mute_last", 32'({out_mute, out_last}), 32'd0);
        check("midreset_queue", 32'(exp_q.size()), 32'd0);
        for (int h = 0; h < 8; h++) push(h, 16'h0000, 1'b0, h == 7);
        do_tick(16'h0010, 9'd8, 1'b0);
        wait_idle("post_midreset_sweep");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/harmonic_phase_engine.md
# harmonic_phase_engine

Parametrised per-harmonic phase accumulator for the additive oscillator. On each sample tick it sweeps harmonics 0..count-1 autonomously. For each harmonic it adds (n+1)×frequency to that harmonic's stored phase and presents the new phase to the sine-LUT stage over a valid/ready handshake. Compared with the single-channel fixed-width generator, it adds:
- parametrised widths and depth,
- its own harmonic sequencing,
- a Nyquist mute flag,
- hard-sync phase reset,
- tick-overrun detection.

## Interface
Parameters:
- PHASE_W, 16, phase accumulator width; top bits index the sine LUT.
- FREQ_W, 16, frequency increment width.
- HARMONICS, 256, phase RAM depth (max harmonics); HARM_W = $clog2(HARMONICS).
- NYQUIST, 2**(PHASE_W-1), accumulated increment at or above which a harmonic is muted.

Ports:
- clock  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- frequency  in  FREQ_W  fundamental phase increment, latched at tick.
- harmonic_count  in  HARM_W+1  harmonics to sweep (0..HARMONICS), latched at tick.
- sample_tick  in  1  one-cycle pulse, start of sample period.
- sync  in  1  hard-sync request pulse.
- out_valid  out  1  out_* fields valid.
- out_ready  in  1  consumer accepts when out_valid&&out_ready.
- out_harmonic  out  HARM_W  harmonic index of current output.
- out_phase  out  PHASE_W  new phase of that harmonic.
- out_mute  out  1  accumulated increment >= NYQUIST.
- out_last  out  1  final harmonic of sweep.
- busy  out  1  sweep in progress (state != IDLE).
- overrun  out  1  sticky: tick arrived while busy; cleared only by reset.

## Operation
- Phase RAM: HARMONICS×PHASE_W, single port, 1-cycle registered read, write-first irrelevant (read and write never target different addresses in the same cycle). Contents are not cleared by reset.
- Latches at tick:
  - freq_l <= frequency, count_l <= harmonic_count.
  - inc <= frequency, zero-extended to ACC_W = FREQ_W+HARM_W+1 (never overflows).
  - idx <= 0.
  - zero_l <= sync_pending, then sync_pending <= 0.
- sync sets sync_pending (sticky until the next tick). sync arriving in the same cycle as a tick applies to that sweep. sync arriving during a sweep applies to the following sweep.
- States:
  - IDLE: on sample_tick && count_l-source != 0 -> READ (RAM addr = idx). A tick with harmonic_count = 0 is ignored: no sweep, no overrun, and sync_pending is kept.
  - READ: wait for RAM data -> CALC.
  - CALC:
    - p = zero_l ? 0 : (rd + inc[PHASE_W-1:0]), mod 2^PHASE_W.
    - Write p to RAM[idx]; register p into out_phase.
    - out_mute = (inc >= NYQUIST); out_last = (idx == count_l-1).
    - -> OUT.
  - OUT: out_valid = 1, fields held stable. On accept:
    - if out_last -> IDLE;
    - else idx <= idx+1, inc <= inc+freq_l, -> READ.
- Muted harmonics still advance and store their phase, so they stay coherent when un-muted.
- sample_tick while busy: ignored for sweep purposes and sets overrun. Its sync behaviour is unchanged (sync still latches into sync_pending).
- Reset (low), including mid-sweep, sets:
  - state IDLE; out_valid, out_mute, out_last, busy, overrun = 0;
  - out_harmonic, out_phase = 0;
  - sync_pending = 1, so the first sweep after reset zeros all phases. This covers the RAM not being cleared.

## Timing
- Tick sampled at cycle T: READ at T+1, CALC at T+2, out_valid high from T+3.
- Throughput: 3 cycles per harmonic with out_ready held high. A full 256-harmonic sweep completes in 768 cycles after the tick.
- out_valid never drops without an accept. All out_* fields change only after an accept or on reset.
- out_ready may be high before out_valid; it has no effect outside OUT.
- busy goes high at T+1 and low the cycle after the last accept.
- The RAM write occurs in CALC, before presentation. The next sweep reads the value written, regardless of consumer stall length.

## Structure
- Shared package harmonic_pkg:
  - state enum (IDLE, READ, CALC, OUT);
  - width defaults and the ACC_W derivation;
  - the NYQUIST default expression.
- Sub-module phase_ram: parametrised inferred single-port RAM (DEPTH, WIDTH) with 1-cycle read. It is the only instance.

## Test plan
- Post-reset sweep: FREQ=0x0100, count=4, tick. Requires:
  - phases 0,0,0,0 (sync_pending after reset), harmonics 0..3;
  - out_last on 3;
  - first out_valid exactly 3 cycles after the tick.
- Second tick, same inputs -> phases 0x0100, 0x0200, 0x0300, 0x0400. Third tick -> 0x0200, 0x0400, 0x0600, 0x0800.
- Nyquist/wrap: FREQ=0x6000, count=3, two sweeps after the zeroing sweep. Requires:
  - mute = 0,1,1 (increments 0x6000, 0xC000, 0x12000 vs 0x8000);
  - sweep-2 phases 0x6000, 0xC000, 0x2000; sweep-3 phases 0xC000, 0x8000, 0x4000 (mod 2^16).
- Backpressure: out_ready low for 10 cycles on harmonic 1. Requires out_* stable throughout, a single accept, and no duplicate or skipped index.
- Overrun and sync: tick at idx 2 of an 8-harmonic sweep -> overrun=1 (sticky), sweep continues to idx 7. sync mid-sweep -> next sweep outputs all-zero phases, the one after outputs (n+1)×FREQ.
- Reset mid-sweep at idx 5 -> all outputs 0 and IDLE the next cycle. The next sweep outputs zero phases.
